// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited imem requests, DEPTH-entry instruction queue, redirect flush, halt.
// Defining FETCH_STATS_EN adds fetch_count/flush_count output ports.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t        r_state, w_state_nx;
    logic [31:0]   r_pc;
    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_cnt, r_out, r_drop;
    logic          r_rst_d;
    logic          w_xfer, w_pop, w_push, w_dropping;
    logic [CW:0]   w_credit;
    logic [CW-1:0] w_inflight;
    logic [31:0]   w_rsp_pc, w_redir_pc;

    // queued words plus in-flight requests never exceed DEPTH, so pushes cannot overflow
    assign w_credit       = {1'b0, r_cnt} + {1'b0, r_out};
    assign imem_req_valid = !rst && !r_rst_d && r_state == S_RUN && !halt && !redirect_valid
                            && w_credit < (CW+1)'(DEPTH);
    assign imem_addr      = r_pc;
    assign w_xfer         = imem_req_valid & imem_req_ready;
    assign ir_valid       = !rst && r_cnt != '0;
    assign ir             = ir_valid ? r_q_data[r_rd] : NOP;
    assign ir_pc          = ir_valid ? r_q_pc[r_rd] : '0;
    assign w_pop          = ir_valid & ir_ready & !redirect_valid;
    assign w_dropping     = r_drop != '0;
    assign w_push         = imem_rsp_valid & !w_dropping & !redirect_valid;
    assign w_redir_pc     = redirect_pc & ~32'h3;
    // kept words are contiguous and end just below pc, so the oldest sits inflight words back
    assign w_inflight     = r_out - r_drop;
    assign w_rsp_pc       = r_pc - {{(30-CW){1'b0}}, w_inflight, 2'b00};

    always_comb begin
        w_state_nx = r_state;
        if (r_state == S_RUN && halt && !redirect_valid)
            w_state_nx = S_HALT;
        else if (r_state == S_HALT && redirect_valid)
            w_state_nx = S_RUN;
    end

    always_ff @(posedge clk) begin
        r_rst_d <= rst;
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_out   <= r_out + CW'(w_xfer) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_pc   <= w_redir_pc;
                r_rd   <= '0;
                r_wr   <= '0;
                r_cnt  <= '0;
                r_drop <= r_out - CW'(imem_rsp_valid);
            end else begin
                if (w_xfer)
                    r_pc <= r_pc + 32'd4;
                if (imem_rsp_valid && w_dropping)
                    r_drop <= r_drop - CW'(1);
                if (w_pop)
                    r_rd <= r_rd + AW'(1);
                if (w_push)
                    r_wr <= r_wr + AW'(1);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr] <= imem_rsp_data;
            r_q_pc[r_wr]   <= w_rsp_pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count, r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_fetch_count <= r_fetch_count + 32'(w_xfer);
            r_flush_count <= r_flush_count + 32'(redirect_valid);
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tasks against an in-order instruction memory model (data = ~addr).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic [31:0] ir, ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, flush_count;
`endif

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    int          pass = 0, total = 0;
    int          cyc_n = 0, lat = 1, last_due = -1;
    bit          rand_mode = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_log[$], pop_log[$], popd_log[$];
    logic        s_req, s_irv;
    logic [31:0] s_addr, s_ir, s_irpc;

    // one clock cycle: drive memory, settle, sample, record, advance to next negedge
    task automatic cyc();
        int d, due;
        imem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq_addr[0];
        end
        #1;
        s_req  = imem_req_valid & imem_req_ready;
        s_addr = imem_addr;
        s_irv  = ir_valid;
        s_ir   = ir;
        s_irpc = ir_pc;
        if (imem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (s_req && !rst) begin
            d   = rand_mode ? $urandom_range(1, 4) : lat;
            due = cyc_n + d;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_addr);
            mq_due.push_back(due);
            req_log.push_back(imem_addr);
        end
        if (ir_valid && ir_ready && !redirect_valid && !rst) begin
            pop_log.push_back(ir_pc);
            popd_log.push_back(ir);
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_reset();
        mq_addr.delete(); mq_due.delete();
        req_log.delete(); pop_log.delete(); popd_log.delete();
        last_due = -1; rand_mode = 0;
        halt = 0; redirect_valid = 0; redirect_pc = '0;
        rst = 1; cyc();
        rst = 0; cyc();
    endtask

    task automatic test_reset();
        mq_addr.delete(); mq_due.delete();
        req_log.delete(); pop_log.delete(); popd_log.delete();
        last_due = -1; ir_ready = 1;
        rst = 1; cyc();
        total++; if (s_req !== 1'b0) $display("FAIL rst_req: got %b want 0", s_req); else pass++;
        total++; if (s_irv !== 1'b0) $display("FAIL rst_irv: got %b want 0", s_irv); else pass++;
        total++; if (s_ir !== 32'h13) $display("FAIL rst_ir: got %h want 00000013", s_ir); else pass++;
        total++; if (s_irpc !== 32'h0) $display("FAIL rst_irpc: got %h want 0", s_irpc); else pass++;
        rst = 0; cyc();
        total++; if (s_req !== 1'b0) $display("FAIL rst1_req: got %b want 0", s_req); else pass++;
        total++; if (s_irv !== 1'b0) $display("FAIL rst1_irv: got %b want 0", s_irv); else pass++;
    endtask

    task automatic test_stream();
        int bad = 0;
        lat = 1; ir_ready = 1; do_reset();
        cyc();
        total++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL t1_req0: got %b/%h want 1/0", s_req, s_addr); else pass++;
        cyc();
        total++; if (s_addr !== 32'h4 || s_irv !== 1'b0) $display("FAIL t1_req4: got %h/%b want 4/0", s_addr, s_irv); else pass++;
        cyc();
        total++; if (s_irv !== 1'b1 || s_irpc !== 32'h0 || s_ir !== ~32'h0) $display("FAIL t1_first_ir: got %b/%h/%h want 1/0/ffffffff", s_irv, s_irpc, s_ir); else pass++;
        repeat (12) cyc();
        for (int i = 0; i < 6; i++) begin
            if (pop_log[i] !== 32'(i * 4)) bad++;
            if (req_log[i] !== 32'(i * 4)) bad++;
        end
        total++; if (bad !== 0) $display("FAIL t1_seq: got %0d bad entries want 0", bad); else pass++;
    endtask

    task automatic test_backpressure();
        lat = 1; ir_ready = 0; do_reset();
        repeat (8) cyc();
        total++; if (req_log.size() !== 2) $display("FAIL t2_nreq: got %0d want 2", req_log.size()); else pass++;
        total++; if (req_log[1] !== 32'h4) $display("FAIL t2_req1: got %h want 4", req_log[1]); else pass++;
        total++; if (s_req !== 1'b0 || s_irv !== 1'b1 || s_irpc !== 32'h0) $display("FAIL t2_hold: got %b/%b/%h want 0/1/0", s_req, s_irv, s_irpc); else pass++;
        ir_ready = 1; cyc(); cyc();
        total++; if (s_irpc !== 32'h4) $display("FAIL t2_next: got %h want 4", s_irpc); else pass++;
    endtask

    task automatic test_redirect();
        int bad = 0;
        lat = 3; ir_ready = 1; do_reset();
        cyc(); cyc();
        redirect_valid = 1; redirect_pc = 32'h103; cyc();
        total++; if (s_req !== 1'b0) $display("FAIL t3_noreq: got %b want 0", s_req); else pass++;
        redirect_valid = 0;
        repeat (12) cyc();
        total++; if (req_log[2] !== 32'h100) $display("FAIL t3_newaddr: got %h want 100", req_log[2]); else pass++;
        total++; if (pop_log[0] !== 32'h100 || popd_log[0] !== ~32'h100) $display("FAIL t3_first: got %h/%h want 100/%h", pop_log[0], popd_log[0], ~32'h100); else pass++;
        total++; if (pop_log[1] !== 32'h104) $display("FAIL t3_second: got %h want 104", pop_log[1]); else pass++;
        foreach (pop_log[i]) if (pop_log[i] < 32'h100) bad++;
        total++; if (bad !== 0) $display("FAIL t3_stale: got %0d old-path words want 0", bad); else pass++;
    endtask

    task automatic test_halt();
        lat = 1; ir_ready = 1; do_reset();
        repeat (4) cyc();
        halt = 1;
        repeat (8) cyc();
        total++; if (req_log.size() !== 3) $display("FAIL t4_nreq: got %0d want 3", req_log.size()); else pass++;
        total++; if (pop_log.size() !== 3 || pop_log[2] !== 32'h8) $display("FAIL t4_drain: got %0d/%h want 3/8", pop_log.size(), pop_log[2]); else pass++;
        halt = 0; cyc(); cyc();
        total++; if (s_req !== 1'b0) $display("FAIL t4_stay: got %b want 0", s_req); else pass++;
        redirect_valid = 1; redirect_pc = 32'h40; cyc();
        redirect_valid = 0; cyc();
        total++; if (s_req !== 1'b1 || s_addr !== 32'h40) $display("FAIL t4_resume: got %b/%h want 1/40", s_req, s_addr); else pass++;
        repeat (4) cyc();
        total++; if (pop_log[3] !== 32'h40) $display("FAIL t4_ir40: got %h want 40", pop_log[3]); else pass++;
    endtask

    task automatic test_wrap();
        lat = 1; ir_ready = 1; do_reset();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8; cyc();
        redirect_valid = 0;
        repeat (10) cyc();
        total++; if (req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) $display("FAIL wrap_req: got %h,%h want fffffffc,0", req_log[1], req_log[2]); else pass++;
        total++; if (pop_log[1] !== 32'hFFFF_FFFC || pop_log[2] !== 32'h0) $display("FAIL wrap_ir: got %h,%h want fffffffc,0", pop_log[1], pop_log[2]); else pass++;
    endtask

    task automatic test_random();
        int bad = 0, badd = 0;
        ir_ready = 1; do_reset();
        rand_mode = 1;
        repeat (300) begin
            ir_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        halt = 1; ir_ready = 1;
        repeat (30) cyc();
        rand_mode = 0; halt = 0;
        for (int i = 0; i < pop_log.size(); i++) begin
            if (pop_log[i] !== 32'(i * 4)) bad++;
            if (popd_log[i] !== ~pop_log[i]) badd++;
        end
        total++; if (bad !== 0) $display("FAIL rnd_seq: got %0d bad pcs want 0", bad); else pass++;
        total++; if (badd !== 0) $display("FAIL rnd_data: got %0d bad words want 0", badd); else pass++;
        total++; if (pop_log.size() !== req_log.size()) $display("FAIL rnd_loss: got %0d pops want %0d", pop_log.size(), req_log.size()); else pass++;
        total++; if (pop_log.size() < 20) $display("FAIL rnd_progress: got %0d pops want >=20", pop_log.size()); else pass++;
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        lat = 1; ir_ready = 1; do_reset();
        total++; if (fetch_count !== 32'h0 || flush_count !== 32'h0) $display("FAIL st_rst: got %0d/%0d want 0/0", fetch_count, flush_count); else pass++;
        for (int i = 0; i < 60; i++) begin
            halt = req_log.size() >= 10;
            redirect_valid = (i == 3 || i == 6);
            redirect_pc = 32'h200;
            cyc();
        end
        redirect_valid = 0; cyc();
        total++; if (fetch_count !== 32'd10 || flush_count !== 32'd2) $display("FAIL st_cnt: got %0d/%0d want 10/2", fetch_count, flush_count); else pass++;
        halt = 0; rst = 1; cyc(); rst = 0; #1;
        total++; if (fetch_count !== 32'h0 || flush_count !== 32'h0) $display("FAIL st_clr: got %0d/%0d want 0/0", fetch_count, flush_count); else pass++;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
